long_maze_plant: RTL and testbench
==================================

LONG_MAZE_PLANT -- requirements
Module: long_maze_plant

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: iupdown  input  1  vertical direction from environment; 0=up (y-1), 1=down (y+1).
REQ-004 SHALL: ileftright  input  1  horizontal direction from environment; 0=left (x-1), 1=right (x+1).
REQ-005 SHALL: controllable_oleftright  input  1  controller enable for the horizontal move this cycle.
REQ-006 SHALL: controllable_oupdown  input  1  controller enable for the vertical move this cycle.
REQ-007 SHALL: pos_x  output  4  current column, 0..15.
REQ-008 SHALL: pos_y  output  3  current row, 0..7.
REQ-009 SHALL: zone1..zone6  output  1 each  zone flags decoded from the registered position; these feed the downstream requirement monitor.
REQ-010 SHALL: bump_cnt  output  4  rejected-move counter.
REQ-011 SHALL: trapped  output  1  sticky; position frozen.
REQ-012 SHALL: error  output  1  high when bump_cnt==15.

Function
REQ-013 SHALL: grid is 16x8; cell (x,y) is a wall iff x==7 and y<=6; (7,7) is the only gap.
REQ-014 SHALL: zone decode, combinational from registered pos_x/pos_y:
- zone1: x in 2..3
- zone2: x in 5..6 and y==7
- zone3: (x,y)==(7,7)
- zone4: x in 8..11 and y==7
- zone5: (x,y)==(15,0)
- zone6: x in 12..13 and y in 3..4
REQ-015 SHALL: zones are non-overlapping, so at most one zone flag is high in any cycle.
REQ-016 SHALL: each non-reset cycle with trapped==0:
- horizontal step first: if controllable_oleftright==1, candidate x' = x±1 per ileftright, evaluated at the current y.
- vertical step second: if controllable_oupdown==1, candidate y' = y±1 per iupdown, evaluated at the post-horizontal x.
REQ-017 SHALL: a candidate is rejected, leaving that coordinate unchanged, if it leaves 0..15 / 0..7 or lands on a wall cell; each component is accepted or rejected independently.
REQ-018 SHALL: bump_cnt increments by exactly 1 in a cycle where at least one enabled component is rejected, even if both are rejected.
REQ-019 SHALL: bump_cnt saturates at 15 and never wraps.
REQ-020 SHALL: new position is visible on pos_x/pos_y and the zone flags one cycle after the edge that sampled the inputs (latency 1).
REQ-021 SHALL: with both enables 0, position and bump_cnt hold.
REQ-022 SHALL: trapped sets on the edge after the registered position is in zone6 and stays set until rst.
REQ-023 SHALL: while trapped==1:
- position is frozen and no bumps are counted;
- zone6 stays 1.
REQ-024 SHALL: error stays high while bump_cnt==15; movement continues while error is high.
REQ-025 SHALL: ileftright and iupdown are ignored when the matching enable is 0.

Reset
REQ-026 SHALL: when rst==1 at posedge, next state is pos=(0,0), bump_cnt=0, trapped=0; hence all zone flags 0 and error=0.
REQ-027 SHALL: rst takes priority over any move and clears a trapped or saturated state in the same edge.
REQ-028 SHALL: no state changes between edges; outputs are defined after the first reset edge.

Verification
REQ-029 SHALL: after reset, oleftright=1, ileftright=1 for 2 cycles -> pos=(2,0), zone1=1, bump_cnt=0.
REQ-030 SHALL: from (0,0), oleftright=1, ileftright=1 for 7 cycles -> pos=(6,0); the 7th move hits the wall, bump_cnt=1, zone1=0.
REQ-031 SHALL: from (0,0), oleftright=1, ileftright=0 for 20 cycles -> pos stays (0,0), bump_cnt=15, error=1.
REQ-032 SHALL: from (6,7), both enables=1, ileftright=1, iupdown=1 -> x'=7 accepted, y'=8 rejected -> pos=(7,7), zone3=1, bump_cnt+1.
REQ-033 SHALL: walk (0,0)->(12,3) via the row-7 gap -> zone6=1, trapped=1 next cycle; further enabled moves leave pos=(12,3); pulse rst -> pos=(0,0), trapped=0, zone6=0.
REQ-034 SHALL: route through zone1..zone5 in order ending at (15,0) -> zone5=1, zone6 never asserted, error=0.

Source files
------------

// File: rtl/long_maze_plant.sv
// ---------------------------------------------------------------------------
// LongMazePlant
// Purpose : a 16x8 grid maze that a controller steers a token through. The
//           environment chooses each step's direction and the controller
//           chooses whether each axis step happens. Column 7 is a wall on rows
//           0..6, so (7,7) is the only way from the left half to the right half.
//           Rejected moves are counted. Parking in zone6 traps the token until
//           reset.
// Ports   :
//   clk                      in   sole clock, rising edge
//   rst                      in   synchronous active-high reset
//   iupdown                  in   vertical direction (0=up y-1, 1=down y+1)
//   ileftright               in   horizontal direction (0=left x-1, 1=right x+1)
//   controllable_oleftright  in   enable for the horizontal step this cycle
//   controllable_oupdown     in   enable for the vertical step this cycle
//   pos_x[3:0]               out  registered column
//   pos_y[2:0]               out  registered row
//   zone1..zone6             out  zone flags decoded from the registered position
//   bump_cnt[3:0]            out  saturating rejected-move counter
//   trapped                  out  sticky freeze flag
//   error                    out  high while bump_cnt is saturated
// ---------------------------------------------------------------------------
module long_maze_plant (
    input  logic       clk,
    input  logic       rst,
    input  logic       iupdown,
    input  logic       ileftright,
    input  logic       controllable_oleftright,
    input  logic       controllable_oupdown,
    output logic [3:0] pos_x,
    output logic [2:0] pos_y,
    output logic       zone1,
    output logic       zone2,
    output logic       zone3,
    output logic       zone4,
    output logic       zone5,
    output logic       zone6,
    output logic [3:0] bump_cnt,
    output logic       trapped,
    output logic       error
);

    logic [3:0] posX_q, posX_d;
    logic [2:0] posY_q, posY_d;
    logic [3:0] bumpCnt_q, bumpCnt_d;
    logic       trapped_q, trapped_d;

    logic       freeze;
    logic       hReject;
    logic       vReject;
    logic [3:0] xCand;
    logic [2:0] yCand;
    logic [3:0] xAfterH;
    logic [2:0] yAfterV;

    // Zone flags come straight from the registered position so they line up
    // with pos_x/pos_y. The zone rectangles do not overlap.
    always_comb begin
        zone1 = (posX_q >= 4'd2) && (posX_q <= 4'd3);
        zone2 = (posX_q >= 4'd5) && (posX_q <= 4'd6) && (posY_q == 3'd7);
        zone3 = (posX_q == 4'd7) && (posY_q == 3'd7);
        zone4 = (posX_q >= 4'd8) && (posX_q <= 4'd11) && (posY_q == 3'd7);
        zone5 = (posX_q == 4'd15) && (posY_q == 3'd0);
        zone6 = (posX_q >= 4'd12) && (posX_q <= 4'd13) &&
                (posY_q >= 3'd3) && (posY_q <= 3'd4);
    end

    // Move evaluation. The horizontal step is resolved first against the
    // current row. The vertical step is then resolved against the column that
    // results, so a diagonal into the gap at (7,7) sees the post-move column.
    // A wall is x==7 with y<=6. Being in zone6 freezes the token, and so does
    // the trapped flag it sets one edge later. This keeps zone6 high for the
    // whole trapped period even if a move is requested on the entry cycle.
    always_comb begin
        freeze    = trapped_q | zone6;
        hReject   = 1'b0;
        vReject   = 1'b0;
        xCand     = posX_q;
        yCand     = posY_q;
        xAfterH   = posX_q;
        yAfterV   = posY_q;
        posX_d    = posX_q;
        posY_d    = posY_q;
        bumpCnt_d = bumpCnt_q;
        trapped_d = trapped_q | zone6;

        if (controllable_oleftright) begin
            if (ileftright) begin
                if (posX_q == 4'd15) hReject = 1'b1;
                else                 xCand   = posX_q + 4'd1;
            end else begin
                if (posX_q == 4'd0)  hReject = 1'b1;
                else                 xCand   = posX_q - 4'd1;
            end
            if (!hReject && (xCand == 4'd7) && (posY_q <= 3'd6)) hReject = 1'b1;
            if (!hReject) xAfterH = xCand;
        end

        if (controllable_oupdown) begin
            if (iupdown) begin
                if (posY_q == 3'd7) vReject = 1'b1;
                else                vReject = 1'b0;
                if (posY_q != 3'd7) yCand = posY_q + 3'd1;
            end else begin
                if (posY_q == 3'd0) vReject = 1'b1;
                else                yCand   = posY_q - 3'd1;
            end
            if (!vReject && (xAfterH == 4'd7) && (yCand <= 3'd6)) vReject = 1'b1;
            if (!vReject) yAfterV = yCand;
        end

        if (!freeze) begin
            posX_d = xAfterH;
            posY_d = yAfterV;
            // One bump per cycle at most, even if both axes are rejected.
            if ((hReject || vReject) && (bumpCnt_q != 4'd15)) begin
                bumpCnt_d = bumpCnt_q + 4'd1;
            end
        end
    end

    // State register. Reset wins over any move and also clears the trapped
    // and saturated conditions.
    always_ff @(posedge clk) begin
        if (rst) begin
            posX_q    <= 4'd0;
            posY_q    <= 3'd0;
            bumpCnt_q <= 4'd0;
            trapped_q <= 1'b0;
        end else begin
            posX_q    <= posX_d;
            posY_q    <= posY_d;
            bumpCnt_q <= bumpCnt_d;
            trapped_q <= trapped_d;
        end
    end

    assign pos_x    = posX_q;
    assign pos_y    = posY_q;
    assign bump_cnt = bumpCnt_q;
    assign trapped  = trapped_q;
    assign error    = (bumpCnt_q == 4'd15);

endmodule

// File: tb/tb_long_maze_plant.sv
// ---------------------------------------------------------------------------
// tb_long_maze_plant
// Purpose : self-checking bench for long_maze_plant. Every step drives the
//           inputs, advances an independent grid model and pushes the
//           expected packed outputs onto a scoreboard queue. After the edge,
//           the result is popped and compared with what the DUT shows.
// Ports   : none (top-level bench)
// ---------------------------------------------------------------------------
module tb_long_maze_plant;

    logic       clk;
    logic       rst;
    logic       iupdown;
    logic       ileftright;
    logic       controllable_oleftright;
    logic       controllable_oupdown;
    logic [3:0] pos_x;
    logic [2:0] pos_y;
    logic       zone1, zone2, zone3, zone4, zone5, zone6;
    logic [3:0] bump_cnt;
    logic       trapped;
    logic       error;

    int checks = 0;
    int errors = 0;

    // Packed view: {x[3:0], y[2:0], zone6..zone1, bump[3:0], trapped, error}
    logic [18:0] obsVec;
    logic [18:0] sbQ[$];

    int mX, mY, mBump, mTrap;

    long_maze_plant dut (
        .clk                     (clk),
        .rst                     (rst),
        .iupdown                 (iupdown),
        .ileftright              (ileftright),
        .controllable_oleftright (controllable_oleftright),
        .controllable_oupdown    (controllable_oupdown),
        .pos_x                   (pos_x),
        .pos_y                   (pos_y),
        .zone1                   (zone1),
        .zone2                   (zone2),
        .zone3                   (zone3),
        .zone4                   (zone4),
        .zone5                   (zone5),
        .zone6                   (zone6),
        .bump_cnt                (bump_cnt),
        .trapped                 (trapped),
        .error                   (error)
    );

    assign obsVec = {pos_x, pos_y, zone6, zone5, zone4, zone3, zone2, zone1,
                     bump_cnt, trapped, error};

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit isWall(int x, int y);
        return (x == 7) && (y <= 6);
    endfunction

    function automatic int zoneOf(int x, int y);
        if (x == 2 || x == 3)                          return 1;
        if ((x == 5 || x == 6) && y == 7)              return 2;
        if (x == 7 && y == 7)                          return 3;
        if (x >= 8 && x <= 11 && y == 7)               return 4;
        if (x == 15 && y == 0)                         return 5;
        if ((x == 12 || x == 13) && (y == 3 || y == 4)) return 6;
        return 0;
    endfunction

    function automatic logic [18:0] expVec();
        logic [5:0] z;
        int zn;
        z  = 6'b0;
        zn = zoneOf(mX, mY);
        if (zn != 0) z[zn-1] = 1'b1;
        return {mX[3:0], mY[2:0], z, mBump[3:0], mTrap[0], (mBump == 15)};
    endfunction

    // Reference model of one clock edge.
    task automatic modelStep(input logic r, input logic eh, input logic dh,
                             input logic ev, input logic dv);
        int nx, ny;
        bit bump;
        bit inZ6;
        if (r) begin
            mX = 0; mY = 0; mBump = 0; mTrap = 0;
            return;
        end
        inZ6 = (zoneOf(mX, mY) == 6);
        bump = 0;
        if (mTrap == 0 && !inZ6) begin
            if (eh) begin
                nx = dh ? mX + 1 : mX - 1;
                if (nx < 0 || nx > 15 || isWall(nx, mY)) bump = 1;
                else mX = nx;
            end
            if (ev) begin
                ny = dv ? mY + 1 : mY - 1;
                if (ny < 0 || ny > 7 || isWall(mX, ny)) bump = 1;
                else mY = ny;
            end
            if (bump && mBump < 15) mBump++;
        end
        if (inZ6) mTrap = 1;
    endtask

    // Drive one cycle of stimulus, queue its expected result, and wait past the edge.
    task automatic applyStimulus(input logic r, input logic eh, input logic dh,
                                 input logic ev, input logic dv);
        rst = r;
        controllable_oleftright = eh;
        ileftright = dh;
        controllable_oupdown = ev;
        iupdown = dv;
        modelStep(r, eh, dh, ev, dv);
        sbQ.push_back(expVec());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] exp;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        exp = sbQ.pop_front();
        checks++;
        if (obsVec !== exp) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", obsVec, exp);
        end
        checks++;
        if (obsVec !== 19'h0) begin
            errors++;
            $display("[TB] FAIL reset_zero: got %h expected 0", obsVec);
        end
    endtask

    // Moves: {eh,dh,ev,dv}. R=1100 L=1000 D=0011 U=0010
    task automatic test_walk_right();
        logic [18:0] exp;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            exp = sbQ.pop_front();
            checks++;
            if (obsVec !== exp) begin
                errors++;
                $display("[TB] FAIL walk_right step%0d: got %h expected %h", i, obsVec, exp);
            end
        end
        checks++;
        if (pos_x !== 4'd2 || pos_y !== 3'd0 || zone1 !== 1'b1 || bump_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL walk_right_final: got x=%0d y=%0d z1=%b bump=%0d expected x=2 y=0 z1=1 bump=0",
                     pos_x, pos_y, zone1, bump_cnt);
        end
    endtask

    task automatic test_wall_hit();
        logic [18:0] exp;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            exp = sbQ.pop_front();
            checks++;
            if (obsVec !== exp) begin
                errors++;
                $display("[TB] FAIL wall_hit step%0d: got %h expected %h", i, obsVec, exp);
            end
        end
        checks++;
        if (pos_x !== 4'd6 || pos_y !== 3'd0 || zone1 !== 1'b0 || bump_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL wall_hit_final: got x=%0d y=%0d z1=%b bump=%0d expected x=6 y=0 z1=0 bump=1",
                     pos_x, pos_y, zone1, bump_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [18:0] exp;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            exp = sbQ.pop_front();
            checks++;
            if (obsVec !== exp) begin
                errors++;
                $display("[TB] FAIL saturate step%0d: got %h expected %h", i, obsVec, exp);
            end
        end
        checks++;
        if (pos_x !== 4'd0 || pos_y !== 3'd0 || bump_cnt !== 4'd15 || error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL saturate_final: got x=%0d y=%0d bump=%0d err=%b expected x=0 y=0 bump=15 err=1",
                     pos_x, pos_y, bump_cnt, error);
        end
        // Movement continues while saturated; idle cycles ignore the direction inputs.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp = sbQ.pop_front();
            if (i == 2) begin
                checks++;
                if (obsVec !== exp) begin
                    errors++;
                    $display("[TB] FAIL saturate_move: got %h expected %h", obsVec, exp);
                end
            end
        end
        checks++;
        if (pos_x !== 4'd1 || pos_y !== 3'd1 || bump_cnt !== 4'd15 || error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL saturate_hold: got x=%0d y=%0d bump=%0d err=%b expected x=1 y=1 bump=15 err=1",
                     pos_x, pos_y, bump_cnt, error);
        end
    endtask

    task automatic test_gap();
        logic [18:0] exp;
        int segN[3] = '{6, 7, 1};
        logic [3:0] segM[3] = '{4'b1100, 4'b0011, 4'b1111};
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        // Double rejection at the corner counts as one bump.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        exp = sbQ.pop_front();
        checks++;
        if (obsVec !== exp || bump_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL double_bump: got %h bump=%0d expected %h bump=1", obsVec, bump_cnt, exp);
        end
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < segN[s]; i++) begin
                applyStimulus(1'b0, segM[s][3], segM[s][2], segM[s][1], segM[s][0]);
                exp = sbQ.pop_front();
                checks++;
                if (obsVec !== exp) begin
                    errors++;
                    $display("[TB] FAIL gap seg%0d step%0d: got %h expected %h", s, i, obsVec, exp);
                end
            end
        end
        checks++;
        if (pos_x !== 4'd7 || pos_y !== 3'd7 || zone3 !== 1'b1 || bump_cnt !== 4'd2) begin
            errors++;
            $display("[TB] FAIL gap_final: got x=%0d y=%0d z3=%b bump=%0d expected x=7 y=7 z3=1 bump=2",
                     pos_x, pos_y, zone3, bump_cnt);
        end
    endtask

    task automatic test_trap();
        logic [18:0] exp;
        int segN[5] = '{6, 7, 5, 4, 1};
        logic [3:0] segM[5] = '{4'b1100, 4'b0011, 4'b1100, 4'b0010, 4'b1100};
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < segN[s]; i++) begin
                applyStimulus(1'b0, segM[s][3], segM[s][2], segM[s][1], segM[s][0]);
                exp = sbQ.pop_front();
                checks++;
                if (obsVec !== exp) begin
                    errors++;
                    $display("[TB] FAIL trap seg%0d step%0d: got %h expected %h", s, i, obsVec, exp);
                end
            end
        end
        checks++;
        if (pos_x !== 4'd12 || pos_y !== 3'd3 || zone6 !== 1'b1 || trapped !== 1'b0) begin
            errors++;
            $display("[TB] FAIL trap_enter: got x=%0d y=%0d z6=%b trapped=%b expected x=12 y=3 z6=1 trapped=0",
                     pos_x, pos_y, zone6, trapped);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        checks++;
        if (trapped !== 1'b1) begin
            errors++;
            $display("[TB] FAIL trap_set: got %b expected 1", trapped);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, i[0], 1'b1, i[1]);
            exp = sbQ.pop_front();
            checks++;
            if (obsVec !== exp || pos_x !== 4'd12 || pos_y !== 3'd3 || zone6 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL trap_frozen step%0d: got %h expected %h", i, obsVec, exp);
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        exp = sbQ.pop_front();
        checks++;
        if (obsVec !== exp || trapped !== 1'b0 || zone6 !== 1'b0 || pos_x !== 4'd0) begin
            errors++;
            $display("[TB] FAIL trap_reset: got %h expected %h", obsVec, exp);
        end
    endtask

    task automatic test_zone_route();
        logic [18:0] exp;
        int segN[7] = '{2, 7, 3, 2, 1, 7, 7};
        logic [3:0] segM[7] = '{4'b1100, 4'b0011, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0010};
        int maxZone;
        bit orderBad;
        bit sawZ6;
        maxZone = 0;
        orderBad = 0;
        sawZ6 = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        for (int s = 0; s < 7; s++) begin
            for (int i = 0; i < segN[s]; i++) begin
                applyStimulus(1'b0, segM[s][3], segM[s][2], segM[s][1], segM[s][0]);
                exp = sbQ.pop_front();
                checks++;
                if (obsVec !== exp) begin
                    errors++;
                    $display("[TB] FAIL route seg%0d step%0d: got %h expected %h", s, i, obsVec, exp);
                end
                if (zone6 === 1'b1) sawZ6 = 1;
                for (int z = 1; z <= 5; z++) begin
                    if (obsVec[5 + z] === 1'b1) begin
                        if (z < maxZone) orderBad = 1;
                        maxZone = z;
                    end
                end
            end
        end
        checks++;
        if (zone5 !== 1'b1 || pos_x !== 4'd15 || pos_y !== 3'd0 || error !== 1'b0 ||
            sawZ6 || orderBad || maxZone != 5) begin
            errors++;
            $display("[TB] FAIL route_final: got z5=%b x=%0d y=%0d err=%b z6seen=%0d order_bad=%0d max=%0d expected z5=1 x=15 y=0 err=0 z6seen=0 order_bad=0 max=5",
                     zone5, pos_x, pos_y, error, sawZ6, orderBad, maxZone);
        end
    endtask

    task automatic test_random();
        logic [18:0] exp;
        logic [4:0] r;
        for (int i = 0; i < 400; i++) begin
            r = 5'($urandom);
            applyStimulus(($urandom_range(0, 59) == 0), r[0], r[1], r[2], r[3]);
            exp = sbQ.pop_front();
            checks++;
            if (obsVec !== exp) begin
                errors++;
                $display("[TB] FAIL random step%0d: got %h expected %h", i, obsVec, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        iupdown = 1'b0;
        ileftright = 1'b0;
        controllable_oleftright = 1'b0;
        controllable_oupdown = 1'b0;
        mX = 0; mY = 0; mBump = 0; mTrap = 0;
        @(negedge clk);
        test_reset();
        test_walk_right();
        test_wall_hit();
        test_saturate();
        test_gap();
        test_trap();
        test_zone_route();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
